// File: rtl/cl_zcash_pkt_arbiter.sv
// Round-robin packet arbiter: merges NUM_SRC packet streams into one registered
// output stream without interleaving, with a mid-packet stall timeout and abort/drain.
module cl_zcash_pkt_arbiter #(
  parameter  int NUM_SRC  = 4,
  parameter  int DAT_BYTS = 8,
  parameter  int MOD_BITS = 3,
  parameter  int TIMEOUT  = 1024,
  localparam int SW = $clog2(NUM_SRC),
  localparam int DW = DAT_BYTS * 8,
  localparam int MW = (MOD_BITS > 0) ? MOD_BITS : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_SRC-1:0]    i_en,
  input  logic [NUM_SRC-1:0]    i_val,
  input  logic [NUM_SRC*DW-1:0] i_dat,
  input  logic [NUM_SRC-1:0]    i_eop,
  input  logic [NUM_SRC*MW-1:0] i_mod,
  output logic [NUM_SRC-1:0]    o_rdy,
  output logic                  o_val,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_err,
  output logic [DW-1:0]         o_dat,
  output logic [MW-1:0]         o_mod,
  output logic [SW-1:0]         o_src,
  input  logic                  i_rdy,
  output logic [15:0]           o_abort_cnt
);

  typedef enum logic [1:0] {IDLE, PKT, ABORT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   grant, rr_ptr, pick;
  logic            pick_vld;
  logic [15:0]     stall_cnt;
  logic            sop_pend;
  logic [NUM_SRC-1:0] cand;

  logic            g_val, g_eop;
  logic [DW-1:0]   g_dat;
  logic [MW-1:0]   g_mod;
  logic            out_free, acc, stall_to, ld_abort, drop_eop;

  assign cand     = i_val & i_en;
  assign g_val    = i_val[grant];
  assign g_eop    = i_eop[grant];
  assign g_dat    = i_dat[grant*DW +: DW];
  assign g_mod    = (MOD_BITS > 0) ? i_mod[grant*MW +: MW] : '0;

  assign out_free = ~o_val | i_rdy;
  assign acc      = (state == PKT) & g_val & out_free;
  assign stall_to = (state == PKT) & ~g_val & (stall_cnt == 16'(TIMEOUT - 1));
  assign ld_abort = (state == ABORT) & out_free;
  assign drop_eop = (state == DRAIN) & g_val & g_eop;

  // Scan from farthest to nearest so the first candidate after rr_ptr wins.
  always_comb begin
    logic [SW-1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = SW'((int'(rr_ptr) + i) % NUM_SRC);
      if (cand[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    o_rdy = '0;
    if (state == PKT)        o_rdy[grant] = out_free;
    else if (state == DRAIN) o_rdy[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pick_vld) state_nxt = PKT;
      PKT: begin
        if (acc && g_eop)  state_nxt = IDLE;
        else if (stall_to) state_nxt = ABORT;
      end
      ABORT: if (out_free) state_nxt = DRAIN;
      DRAIN: if (drop_eop) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant       <= '0;
      rr_ptr      <= SW'(NUM_SRC - 1);
      stall_cnt   <= '0;
      sop_pend    <= 1'b0;
      o_abort_cnt <= '0;
      o_val       <= 1'b0;
      o_sop       <= 1'b0;
      o_eop       <= 1'b0;
      o_err       <= 1'b0;
      o_dat       <= '0;
      o_mod       <= '0;
      o_src       <= '0;
    end else begin
      unique case (state)
        IDLE: if (pick_vld) begin
          grant     <= pick;
          sop_pend  <= 1'b1;
          stall_cnt <= '0;
        end
        PKT: begin
          if (acc) begin
            stall_cnt <= '0;
            if (g_eop) rr_ptr <= grant;
          end else if (!g_val) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
          if (stall_to && o_abort_cnt != 16'hFFFF) o_abort_cnt <= o_abort_cnt + 16'd1;
        end
        DRAIN: if (drop_eop) rr_ptr <= grant;
        default: ;
      endcase

      // Output register: a new word or the abort word replaces a consumed one.
      if (acc) begin
        o_val    <= 1'b1;
        o_sop    <= sop_pend;
        o_eop    <= g_eop;
        o_err    <= 1'b0;
        o_dat    <= g_dat;
        o_mod    <= g_mod;
        o_src    <= grant;
        sop_pend <= 1'b0;
      end else if (ld_abort) begin
        o_val    <= 1'b1;
        o_sop    <= sop_pend;
        o_eop    <= 1'b1;
        o_err    <= 1'b1;
        o_dat    <= '0;
        o_mod    <= '0;
        o_src    <= grant;
        sop_pend <= 1'b0;
      end else if (i_rdy) begin
        o_val    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cl_zcash_pkt_arbiter.sv
// Bench for cl_zcash_pkt_arbiter: queue-fed sources, output recorder and a
// packet-level round-robin reference model.
module tb_cl_zcash_pkt_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int DW = DB * 8;
  localparam int MB = 3;
  localparam int TO = 4;
  localparam int KW = 5 + MB + DW;
  localparam int SNW = 6 + MB + DW;

  typedef struct { logic [DW-1:0] dat; logic [MB-1:0] mod; bit eop; } word_t;
  typedef struct { int src; logic [DW-1:0] dat; logic [MB-1:0] mod; bit sop; bit eop; bit err; int cyc; } out_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [N-1:0]    i_en = '1;
  logic [N-1:0]    i_val = '0;
  logic [N*DW-1:0] i_dat = '0;
  logic [N-1:0]    i_eop = '0;
  logic [N*MB-1:0] i_mod = '0;
  logic [N-1:0]    o_rdy;
  logic            o_val, o_sop, o_eop, o_err;
  logic [DW-1:0]   o_dat;
  logic [MB-1:0]   o_mod;
  logic [1:0]      o_src;
  logic            i_rdy = 1'b1;
  logic [15:0]     o_abort_cnt;

  word_t     srcq [N][$];
  out_t      got_q[$];
  bit [N-1:0] hold = '0;
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;

  cl_zcash_pkt_arbiter #(.NUM_SRC(N), .DAT_BYTS(DB), .MOD_BITS(MB), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_val(i_val), .i_dat(i_dat),
    .i_eop(i_eop), .i_mod(i_mod), .o_rdy(o_rdy), .o_val(o_val), .o_sop(o_sop),
    .o_eop(o_eop), .o_err(o_err), .o_dat(o_dat), .o_mod(o_mod), .o_src(o_src),
    .i_rdy(i_rdy), .o_abort_cnt(o_abort_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [KW-1:0] okey(input out_t o);
    return {o.src[1:0], o.sop, o.eop, o.err, o.mod, o.dat};
  endfunction

  // Sources present their queue heads; handshakes seen at negedge are retired after the edge.
  logic [N-1:0]   hs;
  logic [SNW-1:0] snap, prev_snap;
  bit             stall_prev = 0;
  always begin
    @(negedge i_clk);
    cyc++;
    hs   = i_val & o_rdy;
    snap = {o_val, o_sop, o_eop, o_err, o_src, o_mod, o_dat};
    if (stall_prev && !i_rst) begin
      checks++;
      if (snap !== prev_snap) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%h want=%h", cyc, snap, prev_snap);
      end
    end
    stall_prev = o_val && !i_rdy && !i_rst;
    prev_snap  = snap;
    checks++;
    if ($countones(o_rdy) > 1) begin
      failures++;
      $display("FAIL rdy_onehot cyc=%0d got=%b want=at most one bit", cyc, o_rdy);
    end
    if (o_val && i_rdy)
      got_q.push_back('{int'(o_src), o_dat, o_mod, o_sop, o_eop, o_err, cyc});
    @(posedge i_clk);
    #1;
    if (i_rst) hs = '0;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && srcq[k].size() > 0) srcq[k].delete(0);
      if (srcq[k].size() > 0 && !hold[k]) begin
        i_val[k]          = 1'b1;
        i_dat[k*DW +: DW] = srcq[k][0].dat;
        i_mod[k*MB +: MB] = srcq[k][0].mod;
        i_eop[k]          = srcq[k][0].eop;
      end else begin
        i_val[k] = 1'b0;
        i_eop[k] = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_rdy = 1'b1; i_en = '1; hold = '0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    step(2);
    got_q.delete();
  endtask

  task automatic release_rst();
    step(2);
    i_rst = 1'b0;
  endtask

  task automatic add_pkt(input int k, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.dat = {$urandom, $urandom};
      w.mod = MB'($urandom);
      w.eop = (i == len - 1);
      srcq[k].push_back(w);
    end
  endtask

  // Whole packets in round-robin order starting after source N-1, sop on each first word.
  task automatic model_rr(output out_t ex[$]);
    word_t m[N][$];
    word_t w;
    int ptr, s;
    bit first;
    ex.delete();
    for (int k = 0; k < N; k++) m[k] = srcq[k];
    ptr = N - 1;
    while (1) begin
      s = -1;
      for (int i = 1; i <= N; i++) if (s < 0 && m[(ptr + i) % N].size() > 0) s = (ptr + i) % N;
      if (s < 0) break;
      first = 1;
      do begin
        w = m[s].pop_front();
        ex.push_back('{s, w.dat, w.mod, first, w.eop, 1'b0, 0});
        first = 0;
      end while (!w.eop && m[s].size() > 0);
      ptr = s;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_val, o_sop, o_eop, o_err, o_src, o_mod, o_dat, o_rdy, o_abort_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got val=%b rdy=%b src=%0d dat=%h abort=%0d want all zero", o_val, o_rdy, o_src, o_dat, o_abort_cnt);
    end
    step(1);
    do_reset();
    release_rst();
    step(4);
    checks++;
    if (o_val !== 1'b0 || o_rdy !== '0 || o_abort_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_idle got val=%b rdy=%b abort=%0d want 0 0 0", o_val, o_rdy, o_abort_cnt);
    end
  endtask

  task automatic test_two_pkts();
    out_t ex[$];
    logic [KW-1:0] gk;
    do_reset();
    add_pkt(0, 3); add_pkt(2, 3);
    model_rr(ex);
    release_rst();
    for (int c = 0; c < 100 && got_q.size() < 6; c++) step();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL two_pkts count got=%0d want=6", got_q.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      gk = (i < got_q.size()) ? okey(got_q[i]) : '1;
      checks++;
      if (gk !== okey(ex[i])) begin
        failures++;
        $display("FAIL two_pkts word%0d got=%h want=%h", i, gk, okey(ex[i]));
      end
    end
    if (got_q.size() == 6) begin
      checks++;
      if (got_q[3].cyc - got_q[2].cyc != 2) begin
        failures++;
        $display("FAIL two_pkts dead_cycle got gap=%0d want=2", got_q[3].cyc - got_q[2].cyc);
      end
    end
  endtask

  task automatic test_rr_single();
    out_t ex[$];
    logic [KW-1:0] gk;
    do_reset();
    for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) add_pkt(k, 1);
    model_rr(ex);
    release_rst();
    for (int c = 0; c < 200 && got_q.size() < 12; c++) step();
    for (int i = 0; i < 12; i++) begin
      gk = (i < got_q.size()) ? okey(got_q[i]) : '1;
      checks++;
      if (i >= got_q.size() || got_q[i].src != i % N || !got_q[i].sop || !got_q[i].eop || gk !== okey(ex[i])) begin
        failures++;
        $display("FAIL rr_single word%0d got=%h want=%h (src %0d)", i, gk, okey(ex[i]), i % N);
      end
    end
  endtask

  task automatic test_backpressure();
    out_t ex[$];
    logic [KW-1:0] gk;
    do_reset();
    add_pkt(1, 6);
    model_rr(ex);
    release_rst();
    for (int c = 0; c < 100 && got_q.size() < 2; c++) step();
    i_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      checks++;
      if (o_rdy[1] !== 1'b0 || o_val !== 1'b1 || o_src !== 2'd1) begin
        failures++;
        $display("FAIL backpressure cyc%0d got rdy=%b val=%b src=%0d want rdy1=0 val=1 src=1", c, o_rdy, o_val, o_src);
      end
      step();
    end
    i_rdy = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < 6; c++) step();
    step(3);
    checks++;
    if (got_q.size() != ex.size()) begin
      failures++;
      $display("FAIL backpressure count got=%0d want=%0d", got_q.size(), ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      gk = (i < got_q.size()) ? okey(got_q[i]) : '1;
      checks++;
      if (gk !== okey(ex[i])) begin
        failures++;
        $display("FAIL backpressure word%0d got=%h want=%h", i, gk, okey(ex[i]));
      end
    end
  endtask

  task automatic test_timeout();
    word_t w;
    out_t  ab;
    do_reset();
    w.dat = 64'h1111_2222_3333_4444; w.mod = 3'd5; w.eop = 0;
    srcq[1].push_back(w);
    release_rst();
    for (int c = 0; c < 60 && got_q.size() < 2; c++) step();
    checks++;
    if (got_q.size() < 2) begin
      failures++;
      $display("FAIL timeout error_word got words=%0d want=2", got_q.size());
    end else begin
      ab = '{1, '0, '0, 1'b0, 1'b1, 1'b1, 0};
      checks++;
      if (okey(got_q[0]) !== {2'd1, 1'b1, 1'b0, 1'b0, 3'd5, 64'h1111_2222_3333_4444}) begin
        failures++;
        $display("FAIL timeout first_word got=%h", okey(got_q[0]));
      end
      checks++;
      if (okey(got_q[1]) !== okey(ab)) begin
        failures++;
        $display("FAIL timeout abort_word got=%h want=%h", okey(got_q[1]), okey(ab));
      end
      checks++;
      if (got_q[1].cyc - got_q[0].cyc != TO + 1) begin
        failures++;
        $display("FAIL timeout latency got=%0d want=%0d", got_q[1].cyc - got_q[0].cyc, TO + 1);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_rdy !== 4'b0010) begin
      failures++;
      $display("FAIL timeout drain_rdy got=%b want=0010", o_rdy);
    end
    step();
    w.eop = 0; srcq[1].push_back(w);
    w.eop = 1; srcq[1].push_back(w);
    step(10);
    checks++;
    if (srcq[1].size() != 0 || got_q.size() != 2 || o_abort_cnt !== 16'd1) begin
      failures++;
      $display("FAIL timeout drain got left=%0d words=%0d abort=%0d want 0 2 1", srcq[1].size(), got_q.size(), o_abort_cnt);
    end
    add_pkt(2, 1);
    for (int c = 0; c < 40 && got_q.size() < 3; c++) step();
    checks++;
    if (got_q.size() < 3 || got_q[2].src != 2 || !got_q[2].sop || !got_q[2].eop || got_q[2].err) begin
      failures++;
      $display("FAIL timeout recover got words=%0d want src2 sop eop word", got_q.size());
    end
  endtask

  task automatic test_enable();
    out_t ex[$];
    logic [KW-1:0] gk;
    do_reset();
    add_pkt(0, 3); add_pkt(0, 1); add_pkt(3, 1);
    model_rr(ex);
    release_rst();
    for (int c = 0; c < 50 && got_q.size() < 1; c++) step();
    i_en[0] = 1'b0;
    for (int c = 0; c < 50 && got_q.size() < 4; c++) step();
    step(15);
    checks++;
    if (got_q.size() != 4 || got_q[3].src != 3) begin
      failures++;
      $display("FAIL enable gated got words=%0d want=4 ending with src3", got_q.size());
    end
    i_en[0] = 1'b1;
    for (int c = 0; c < 50 && got_q.size() < 5; c++) step();
    for (int i = 0; i < ex.size(); i++) begin
      gk = (i < got_q.size()) ? okey(got_q[i]) : '1;
      checks++;
      if (gk !== okey(ex[i])) begin
        failures++;
        $display("FAIL enable word%0d got=%h want=%h", i, gk, okey(ex[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    add_pkt(0, 6);
    release_rst();
    for (int c = 0; c < 50 && got_q.size() < 2; c++) step();
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_val, o_sop, o_eop, o_err, o_src, o_mod, o_dat, o_rdy, o_abort_cnt} !== '0) begin
      failures++;
      $display("FAIL async_reset got val=%b rdy=%b dat=%h want all zero", o_val, o_rdy, o_dat);
    end
    for (int k = 0; k < N; k++) srcq[k].delete();
    step(2);
    got_q.delete();
    add_pkt(2, 1); add_pkt(0, 1);
    release_rst();
    for (int c = 0; c < 50 && got_q.size() < 2; c++) step();
    checks++;
    if (got_q.size() != 2 || got_q[0].src != 0 || got_q[1].src != 2 || got_q[0].err || got_q[1].err) begin
      failures++;
      $display("FAIL async_reset first_grant got words=%0d first_src=%0d want 2 words from src0 then src2", got_q.size(), (got_q.size() > 0) ? got_q[0].src : -1);
    end
  endtask

  task automatic test_random();
    out_t ex[$];
    logic [KW-1:0] gk;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < N; k++) repeat ($urandom_range(0, 3)) add_pkt(k, $urandom_range(1, 4));
      model_rr(ex);
      release_rst();
      for (int c = 0; c < 2000 && got_q.size() < ex.size(); c++) begin
        i_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      i_rdy = 1'b1;
      step(3);
      checks++;
      if (got_q.size() != ex.size()) begin
        failures++;
        $display("FAIL random%0d count got=%0d want=%0d", r, got_q.size(), ex.size());
      end
      for (int i = 0; i < ex.size(); i++) begin
        gk = (i < got_q.size()) ? okey(got_q[i]) : '1;
        checks++;
        if (gk !== okey(ex[i])) begin
          failures++;
          $display("FAIL random%0d word%0d got=%h want=%h", r, i, gk, okey(ex[i]));
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_two_pkts();
    test_rr_single();
    test_backpressure();
    test_timeout();
    test_enable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
